// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store controller.
// Size codes, FSM states and the alignment rule live here so RTL and users agree.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_DATA,
        ST_RD,
        ST_WR,
        ERR,
        RESP
    } state_e;

    // size 2'b11 has no meaning, so it is rejected the same way as a bad alignment
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory port bundle of the load/store controller.
// slave = controller side; master = pipeline plus memory side.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [WORD_WIDTH-1:0] resp_rdata;
    logic                  resp_misalign;
    logic                  mem_write;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign,
               mem_write, mem_read, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign,
               mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/sign-extend and sub-word store merge.
// Purely combinational; the caller guarantees the offset is legal for the size.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (off_i)
            2'd0:    byte_lane = old_i[7:0];
            2'd1:    byte_lane = old_i[15:8];
            2'd2:    byte_lane = old_i[23:16];
            default: byte_lane = old_i[31:24];
        endcase
        half_lane = off_i[1] ? old_i[31:16] : old_i[15:0];

        case (size_i)
            SZ_BYTE: ld_data_o = {{24{~uns_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: ld_data_o = {{16{~uns_i & half_lane[15]}}, half_lane};
            default: ld_data_o = old_i;
        endcase
    end

    always_comb begin
        st_word_o = old_i;
        case (size_i)
            SZ_BYTE: begin
                case (off_i)
                    2'd0:    st_word_o[7:0]   = new_i[7:0];
                    2'd1:    st_word_o[15:8]  = new_i[7:0];
                    2'd2:    st_word_o[23:16] = new_i[7:0];
                    default: st_word_o[31:24] = new_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off_i[1]) st_word_o[31:16] = new_i[15:0];
                else          st_word_o[15:0]  = new_i[15:0];
            end
            default: st_word_o = new_i;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller in front of a word-addressed data memory.
// One request at a time; sub-word stores are done as read-modify-write.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    lsu_mem_ctrl_if.slave bus
);
    state_e                state_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic                  resp_valid_q;
    logic                  resp_misalign_q;
    logic [WORD_WIDTH-1:0] resp_rdata_q;

    logic [WORD_WIDTH-1:0] ld_data;
    logic [WORD_WIDTH-1:0] st_word;
    logic                  mem_rd;
    logic                  mem_wr;

    lsu_lane_align u_align (
        .size_i    (size_q),
        .off_i     (addr_q[1:0]),
        .uns_i     (uns_q),
        .old_i     (bus.mem_rdata),
        .new_i     (wdata_q),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            resp_valid_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
            resp_rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (is_misaligned(bus.req_size, bus.req_addr[1:0])) state_q <= ERR;
                        else if (!bus.req_we)                               state_q <= LD_RD;
                        else if (bus.req_size == SZ_WORD)                   state_q <= ST_WR;
                        else                                                state_q <= ST_RD;
                    end
                end
                LD_RD:   state_q <= LD_DATA;
                LD_DATA: begin
                    resp_rdata_q <= ld_data;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                ST_RD:   state_q <= ST_WR;
                ST_WR: begin
                    resp_rdata_q <= '0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                ERR: begin
                    resp_misalign_q <= 1'b1;
                    resp_rdata_q    <= '0;
                    resp_valid_q    <= 1'b1;
                    state_q         <= RESP;
                end
                RESP: begin
                    resp_valid_q    <= 1'b0;
                    resp_misalign_q <= 1'b0;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // memory strobes come straight from state so an async reset kills them at once
    assign mem_rd = (state_q == LD_RD) || (state_q == ST_RD);
    assign mem_wr = (state_q == ST_WR);

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.mem_read      = mem_rd;
    assign bus.mem_write     = mem_wr;
    assign bus.mem_addr      = (mem_rd || mem_wr) ? {2'b00, addr_q[ADDR_WIDTH-1:2]} : '0;
    assign bus.mem_wdata     = mem_wr ? st_word : '0;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_misalign = resp_misalign_q;
    assign bus.resp_rdata    = resp_rdata_q;

    logic unused_we;
    assign unused_we = we_q;
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller that sits directly upstream of the word-addressed data memory in the MEM stage.
- Accepts byte-addressed load/store requests of byte, halfword or word size from the pipeline and drives the memory's mem_write/mem_read/mem_addr/mem_wdata port.
- Performs read-modify-write for sub-word stores and lane extraction/sign-extension for loads.
- Returns one response per request and flags misaligned accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, width of request byte address and of memory word address.
- WORD_WIDTH, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request (IDLE only)
- req_we  input  1  1=store, 0=load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  load zero-extends when 1
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  WORD_WIDTH  store data, right-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  WORD_WIDTH  load result (0 for stores and errors)
- resp_misalign  output  1  request rejected as misaligned/illegal
- mem_write  output  1  memory write strobe
- mem_read  output  1  memory read strobe
- mem_addr  output  ADDR_WIDTH  word address = latched req_addr >> 2, upper bits zero
- mem_wdata  output  WORD_WIDTH  full word written
- mem_rdata  input  WORD_WIDTH  memory read data, valid the cycle after mem_read, held until the next read

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - resp_valid, resp_misalign and resp_rdata are 0; latched request registers are 0.
  - mem_write, mem_read, mem_addr and mem_wdata are 0. They are decoded from state, so they drop immediately.
  - A store in flight when reset asserts is dropped. No write occurs after reset release.
- Handshake:
  - Accept happens when req_valid && req_ready on a clk edge; the request is latched at that edge.
  - req_ready is 1 only in IDLE.
  - The requester holds inputs stable until accepted. Requests while not ready are ignored.
  - There is no response backpressure.
- Misalignment:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - size=11 is illegal and is treated as misaligned.
- Lanes (little-endian):
  - Byte k occupies bits 8k+7:8k, k=addr[1:0].
  - Half h occupies bits 16h+15:16h, h=addr[1].
- States:
  - IDLE: on accept go to ERR if misaligned. Otherwise a load goes to LD_RD, a word store goes to ST_WR, and a sub-word store goes to ST_RD.
  - LD_RD: mem_read=1 -> LD_DATA.
  - LD_DATA: extract lane from mem_rdata, sign-extend from bit 7/15 unless unsigned (word passes through), register into resp_rdata -> RESP.
  - ST_RD: mem_read=1 -> ST_WR.
  - ST_WR: mem_write=1. mem_wdata is either the latched word, or mem_rdata with the addressed lane(s) replaced by the low 8/16 bits of the latched wdata (merge from mem_rdata, stable this cycle). resp_rdata<=0 -> RESP.
  - ERR: resp_misalign<=1, resp_rdata<=0 -> RESP. No mem_read/mem_write are ever asserted for the request.
  - RESP: resp_valid=1 -> IDLE. resp_misalign clears when leaving RESP.
- Latency, counted from the accept edge (cycle 0):
  - Word store: write in cycle 1, resp in cycle 2.
  - Sub-word store: read in cycle 1, write in cycle 2, resp in cycle 3.
  - Load: read in cycle 1, resp in cycle 3.
  - Misaligned/illegal: resp in cycle 2.
- mem_read and mem_write are never asserted in the same cycle.
- Next accept is possible in the cycle after RESP.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum IDLE/LD_RD/LD_DATA/ST_RD/ST_WR/ERR/RESP;
  - a misalignment check function.
- Sub-module lsu_lane_align (combinational) performs load extract/sign-extend and store merge, from size, addr[1:0], unsigned, old word and new data.
- The FSM and registers stay in lsu_mem_ctrl.

Test Plan:
- Reset mid-op: assert rst low during ST_WR of word store 0x11223344 @0x20 -> mem_write falls immediately; memory word 8 is unchanged; after release req_ready=1 and no mem_write occurs.
- Word store 0xDEADBEEF @0x10 -> cycle 1 mem_write=1, mem_addr=4, mem_wdata=0xDEADBEEF; cycle 2 resp_valid=1, resp_rdata=0.
- Byte store 0xA5 @0x12 over 0xDEADBEEF -> cycle 1 mem_read=1, mem_addr=4; cycle 2 mem_wdata=0xDEA5BEEF; cycle 3 resp.
- Loads @0x12 of 0xDEA5BEEF -> byte signed 0xFFFFFFA5, byte unsigned 0x000000A5, half signed 0xFFFFDEA5, half unsigned 0x0000DEA5; word @0x10 gives 0xDEA5BEEF; each resp at cycle 3.
- Half load @0x13 and word load @0x12 -> resp_misalign=1, resp_rdata=0 at cycle 2; mem_read/mem_write stay 0 throughout.
- req_valid held high with word load then byte store -> req_ready low from cycle 1 to RESP; second request accepted the cycle after RESP; exactly two resp_valid pulses.
